param_jk_register: RTL and testbench

PARAM_JK_REGISTER -- requirements
Module: param_jk_register

---
 rtl/jk_pkg.sv | 24 ++
 rtl/jk_cell.sv | 22 ++
 rtl/param_jk_register.sv | 104 ++++++++++
 tb/tb_param_jk_register.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the parameterised JK register: mode encodings and
// the terminal-count helper used by the top level.
package jk_pkg;

    // Operation select encodings on the 2-bit mode port.
    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b11;

    // Widest register the block is intended to be built with.
    localparam int MAX_WIDTH = 32;

    // Terminal count: the next counting step would wrap the register.
    function automatic logic count_terminal(
        input logic [1:0] mode,
        input logic       all_ones,
        input logic       all_zero
    );
        return ((mode == MODE_UP)   && all_ones) ||
               ((mode == MODE_DOWN) && all_zero);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK next-state function. Purely combinational; the flop lives in
// the parent so that all state sits in one clocked process.
module jk_cell (
    input  logic j,
    input  logic k,
    input  logic q,
    output logic q_next
);

    // Classic JK truth table: hold, clear, set, toggle.
    always_comb begin
        // NOTE: a default before the case keeps this purely combinational; a missed branch would otherwise infer a latch.
        q_next = q;
        case ({j, k})
            2'b00: q_next = q;
            2'b01: q_next = 1'b0;
            2'b10: q_next = 1'b1;
            2'b11: q_next = ~q;
        endcase
    end

endmodule

// File: rtl/param_jk_register.sv
// Parameterised register of JK cells. Every mode is mapped onto per-bit J/K
// drives so the same cell array does JK, parallel load and up/down counting:
//   JK   : j/k from the ports
//   LOAD : j = d, k = ~d  (set where d=1, clear where d=0)
//   UP   : j = k = toggle chain over ones
//   DOWN : j = k = toggle chain over zeros
module param_jk_register
    import jk_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             chg
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             chg_q;
    logic             chg_d;

    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic [WIDTH-1:0] cell_next;

    // Ripple toggle chain: bit i flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        toggle    = '0;
        toggle[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            if (mode == MODE_DOWN) begin
                toggle[i] = toggle[i-1] & ~q_q[i-1];
            end else begin
                toggle[i] = toggle[i-1] & q_q[i-1];
            end
        end
    end

    // Map the selected operation onto per-bit J/K drives.
    always_comb begin
        cell_j = j;
        cell_k = k;
        case (mode)
            MODE_JK: begin
                cell_j = j;
                cell_k = k;
            end
            MODE_LOAD: begin
                cell_j = d;
                cell_k = ~d;
            end
            MODE_UP, MODE_DOWN: begin
                cell_j = toggle;
                cell_k = toggle;
            end
        endcase
    end

    // One JK cell per bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .j      (cell_j[gi]),
            .k      (cell_k[gi]),
            .q      (q_q[gi]),
            .q_next (cell_next[gi])
        );
    end

    // Next state: enable gates the update; chg flags any bit that will move.
    always_comb begin
        q_d   = q_q;
        chg_d = 1'b0;
        if (en) begin
            q_d = cell_next;
        end
        chg_d = (q_d != q_q);
    end

    // State register with asynchronous reset to RST_VAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= RST_VAL;
            chg_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

    assign q   = q_q;
    assign chg = chg_q;
    assign tc  = en && count_terminal(mode, &q_q, ~|q_q);

endmodule

// File: tb/tb_param_jk_register.sv
// Directed bench for param_jk_register (WIDTH=8, RST_VAL=8'hA5). A vector
// table walks through JK, load, wrap and hold behaviour; hand-written
// sequences cover asynchronous reset mid-count and an edge under reset.
module tb_param_jk_register;
    import jk_pkg::*;

    localparam int               WIDTH   = 8;
    localparam logic [WIDTH-1:0] RST_VAL = 8'hA5;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             chg;

    int checks;
    int errors;

    typedef struct {
        string      name;
        logic       en;
        logic [1:0] mode;
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] d;
        logic       exp_tc;   // tc before the edge
        logic [7:0] exp_q;    // q after the edge
        logic       exp_chg;  // chg after the edge
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    param_jk_register #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .j    (j),
        .k    (k),
        .d    (d),
        .q    (q),
        .tc   (tc),
        .chg  (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [1:0] m,
                         input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] dd);
        en   = e;
        mode = m;
        j    = jj;
        k    = kk;
        d    = dd;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            name          en    mode       j      k      d      tc    q      chg
        vecs[0]  = '{"load_0f",    1'b1, MODE_LOAD, 8'h00, 8'h00, 8'h0F, 1'b0, 8'h0F, 1'b1};
        vecs[1]  = '{"jk_f3",      1'b1, MODE_JK,   8'hF0, 8'h3C, 8'h00, 1'b0, 8'hF3, 1'b1};
        vecs[2]  = '{"jk_hold",    1'b1, MODE_JK,   8'h00, 8'h00, 8'h55, 1'b0, 8'hF3, 1'b0};
        vecs[3]  = '{"load_fe",    1'b1, MODE_LOAD, 8'hFF, 8'hFF, 8'hFE, 1'b0, 8'hFE, 1'b1};
        vecs[4]  = '{"up_ff",      1'b1, MODE_UP,   8'h00, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1};
        vecs[5]  = '{"up_wrap",    1'b1, MODE_UP,   8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[6]  = '{"up_01",      1'b1, MODE_UP,   8'h00, 8'h00, 8'h00, 1'b0, 8'h01, 1'b1};
        vecs[7]  = '{"load_same",  1'b1, MODE_LOAD, 8'h00, 8'h00, 8'h01, 1'b0, 8'h01, 1'b0};
        vecs[8]  = '{"down_00",    1'b1, MODE_DOWN, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[9]  = '{"down_wrap",  1'b1, MODE_DOWN, 8'h00, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[10] = '{"hold_jk",    1'b0, MODE_JK,   8'h00, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[11] = '{"hold_load",  1'b0, MODE_LOAD, 8'h00, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[12] = '{"hold_up",    1'b0, MODE_UP,   8'h00, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[13] = '{"hold_down",  1'b0, MODE_DOWN, 8'h00, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[14] = '{"up_ff_00",   1'b1, MODE_UP,   8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[15] = '{"down_00_ff", 1'b1, MODE_DOWN, 8'h00, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[16] = '{"jk_toggle",  1'b1, MODE_JK,   8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[17] = '{"load_10",    1'b1, MODE_LOAD, 8'h00, 8'h00, 8'h10, 1'b0, 8'h10, 1'b1};

        // Reset asserted between edges: values appear without a clock edge.
        drive(1'b0, MODE_JK, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_q", 32'(q), 32'(RST_VAL));
        check("rst_chg", 32'(chg), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors; state carries from one row to the next.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].en, vecs[i].mode, vecs[i].j, vecs[i].k, vecs[i].d);
            #1;
            check({vecs[i].name, "_tc"}, 32'(tc), 32'(vecs[i].exp_tc));
            @(posedge clk);
            #1;
            check({vecs[i].name, "_q"}, 32'(q), 32'(vecs[i].exp_q));
            check({vecs[i].name, "_chg"}, 32'(chg), 32'(vecs[i].exp_chg));
            @(negedge clk);
        end

        // Count up from 8'h10 for three edges, then reset mid-count.
        drive(1'b1, MODE_UP, 8'h00, 8'h00, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check("count_q", 32'(q), 32'(8'h10 + i));
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midcount_rst_q", 32'(q), 32'(RST_VAL));
        check("midcount_rst_chg", 32'(chg), 32'd0);

        // An edge while rst is held must not count.
        @(posedge clk);
        #1;
        check("edge_under_rst_q", 32'(q), 32'(RST_VAL));
        check("edge_under_rst_chg", 32'(chg), 32'd0);

        // First edge after release performs a normal count.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_q", 32'(q), 32'(RST_VAL + 8'd1));
        check("post_rst_chg", 32'(chg), 32'd1);

        // Mode switch takes effect on the very next edge (count down from A6).
        @(negedge clk);
        mode = MODE_DOWN;
        @(posedge clk);
        #1;
        check("mode_switch_q", 32'(q), 32'(RST_VAL));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
